// File: rtl/upsample_pkg.sv
// upsample_pkg: FSM encoding and counter-width helper shared by
// the upsample_nx block and its line buffer.
package upsample_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_REPEAT = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Smallest width >= 1 that can index n entries.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < n) w = i + 1;
    return w;
  endfunction

endpackage

// File: rtl/up_line_buf.sv
// up_line_buf: simple dual-port row store, one write and one
// registered read port, storage left unreset so it maps to RAM.
module up_line_buf
  import upsample_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 26,
  parameter int AW     = clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // Read data holds until the next read is issued.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/upsample_nx.sv
// upsample_nx: nearest-neighbour SCALE x SCALE stream upsampler.
// Define UPSAMPLE_BYPASS_EN to enable the 1:1 cfg_bypass frame mode.
module upsample_nx
  import upsample_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int COL_NUM = 26,
  parameter int ROW_NUM = 416,
  parameter int SCALE   = 2
) (
  input  logic              sclk,
  input  logic              s_rst,
  input  logic              start,
  input  logic              cfg_bypass,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              busy,
  output logic              done
);

  localparam int COL_W = clog2(COL_NUM);
  localparam int ROW_W = clog2(ROW_NUM);
  localparam int SC_W  = clog2(SCALE);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(COL_NUM - 1);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(ROW_NUM - 1);
  localparam logic [SC_W-1:0]  H_MAX   = SC_W'(SCALE - 1);
  localparam logic [SC_W-1:0]  V_MAX   =
    SC_W'((SCALE > 1) ? SCALE - 2 : 0);

  state_t r_state, w_next;

  logic [COL_W-1:0]  r_col;
  logic [SC_W-1:0]   r_hcp;
  logic [SC_W-1:0]   r_vcp;
  logic [ROW_W-1:0]  r_row;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_mdata;
  logic              r_mvalid;
  logic              r_mlast;
  logic              r_done;

  logic              w_adv;
  logic              w_srdy;
  logic              w_in_hs;
  logic              w_emit;
  logic              w_hlast;
  logic              w_clast;
  logic              w_vlast;
  logic              w_rlast;
  logic              w_norep;
  logic              w_pass_end;
  logic              w_row_end;
  logic              w_final;
  logic              w_out_hs;
  logic              w_rd_en;
  logic [SC_W-1:0]   w_hmax;
  logic [COL_W-1:0]  w_rd_addr;
  logic [DATA_W-1:0] w_rd_data;
  logic [DATA_W-1:0] w_odata;

`ifdef UPSAMPLE_BYPASS_EN
  logic r_bypass;

  always_ff @(posedge sclk) begin
    if (s_rst)
      r_bypass <= 1'b0;
    else if (r_state == ST_IDLE && start)
      r_bypass <= cfg_bypass;
  end

  assign w_hmax  = r_bypass ? '0 : H_MAX;
  assign w_norep = r_bypass || (SCALE == 1);
`else
  logic w_unused;
  assign w_unused = cfg_bypass;
  assign w_hmax   = H_MAX;
  assign w_norep  = (SCALE == 1);
`endif

  assign w_adv    = !r_mvalid || m_tready;
  assign w_out_hs = r_mvalid && m_tready;
  assign w_hlast  = (r_hcp == w_hmax);
  assign w_clast  = (r_col == COL_MAX);
  assign w_vlast  = (r_vcp == V_MAX);
  assign w_rlast  = (r_row == ROW_MAX);
  assign w_in_hs  = s_tvalid && w_srdy;

  assign w_pass_end = w_emit && w_hlast && w_clast;
  assign w_final    = w_row_end && w_rlast;

  // Next column is fetched on its predecessor's last copy so
  // replay keeps one beat per cycle.
  assign w_rd_addr = w_clast ? '0 : r_col + 1'b1;

  always_ff @(posedge sclk) begin
    if (s_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:
        if (start) w_next = ST_FILL;
      ST_FILL:
        if (w_pass_end)
          w_next = !w_norep ? ST_REPEAT :
                   w_rlast  ? ST_DONE : ST_FILL;
      ST_REPEAT:
        if (w_row_end)
          w_next = w_rlast ? ST_DONE : ST_FILL;
      ST_DONE:
        if (w_out_hs && r_mlast) w_next = ST_IDLE;
      default:
        w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_srdy    = 1'b0;
    w_emit    = 1'b0;
    w_odata   = r_hold;
    w_row_end = 1'b0;
    w_rd_en   = 1'b0;
    unique case (r_state)
      ST_FILL: begin
        w_srdy    = (r_hcp == '0) && w_adv;
        w_emit    = (r_hcp == '0) ? (s_tvalid && w_srdy) : w_adv;
        w_odata   = (r_hcp == '0) ? s_tdata : r_hold;
        w_row_end = w_pass_end && w_norep;
        w_rd_en   = w_pass_end && !w_norep;
      end
      ST_REPEAT: begin
        w_emit    = w_adv;
        w_odata   = w_rd_data;
        w_row_end = w_pass_end && w_vlast;
        w_rd_en   = w_emit && w_hlast;
      end
      default: ;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      r_hcp <= '0;
      r_col <= '0;
      r_vcp <= '0;
      r_row <= '0;
    end else if (w_emit) begin
      r_hcp <= w_hlast ? '0 : r_hcp + 1'b1;
      if (w_hlast)
        r_col <= w_clast ? '0 : r_col + 1'b1;
      if (w_pass_end && r_state == ST_REPEAT)
        r_vcp <= w_vlast ? '0 : r_vcp + 1'b1;
      if (w_row_end)
        r_row <= w_rlast ? '0 : r_row + 1'b1;
    end
  end

  always_ff @(posedge sclk) begin
    if (w_in_hs) r_hold <= s_tdata;
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      r_mvalid <= 1'b0;
      r_mlast  <= 1'b0;
      r_mdata  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_out_hs && r_mlast;
      if (w_adv) begin
        r_mvalid <= w_emit;
        r_mlast  <= w_emit && w_final;
        if (w_emit) r_mdata <= w_odata;
      end
    end
  end

  up_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (COL_NUM),
    .AW     (COL_W)
  ) u_line_buf (
    .i_clk     (sclk),
    .i_wr_en   (w_in_hs),
    .i_wr_addr (r_col),
    .i_wr_data (s_tdata),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  assign s_tready = w_srdy;
  assign m_tdata  = r_mdata;
  assign m_tvalid = r_mvalid;
  assign m_tlast  = r_mlast;
  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;

endmodule

// File: tb/tb_upsample_nx.sv
// tb_upsample_nx: directed and randomized frames on two upsampler
// instances checked against a row/copy reference model.
module tb_upsample_nx;

  localparam int DW = 16;
  localparam int CA = 4;
  localparam int RA = 2;
  localparam int SA = 2;

  logic sclk = 1'b0;
  always #5 sclk = ~sclk;

  logic s_rst;

  logic          a_start, a_byp, a_svld, a_srdy;
  logic          a_mval, a_mrdy, a_mlast, a_busy, a_done;
  logic [DW-1:0] a_sdata, a_mdata;

  logic          b_start, b_byp, b_svld, b_srdy;
  logic          b_mval, b_mrdy, b_mlast, b_busy, b_done;
  logic [DW-1:0] b_sdata, b_mdata;

  int n_chk = 0;
  int n_err = 0;

  upsample_nx #(
    .DATA_W (DW), .COL_NUM (CA), .ROW_NUM (RA), .SCALE (SA)
  ) dut_a (
    .sclk       (sclk),
    .s_rst      (s_rst),
    .start      (a_start),
    .cfg_bypass (a_byp),
    .s_tdata    (a_sdata),
    .s_tvalid   (a_svld),
    .s_tready   (a_srdy),
    .m_tdata    (a_mdata),
    .m_tvalid   (a_mval),
    .m_tready   (a_mrdy),
    .m_tlast    (a_mlast),
    .busy       (a_busy),
    .done       (a_done)
  );

  upsample_nx #(
    .DATA_W (DW), .COL_NUM (2), .ROW_NUM (1), .SCALE (3)
  ) dut_b (
    .sclk       (sclk),
    .s_rst      (s_rst),
    .start      (b_start),
    .cfg_bypass (b_byp),
    .s_tdata    (b_sdata),
    .s_tvalid   (b_svld),
    .s_tready   (b_srdy),
    .m_tdata    (b_mdata),
    .m_tvalid   (b_mval),
    .m_tready   (b_mrdy),
    .m_tlast    (b_mlast),
    .busy       (b_busy),
    .done       (b_done)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One frame on dut_a. rdy/vld are percent probabilities;
  // rst_at >= 0 aborts after that many output beats.
  task automatic run_a(input bit byp, input int rdy, input int vld,
                       input bit rnd, input int rst_at,
                       input int glitch_at, input string tag);
    logic [DW-1:0] in_q [CA*RA];
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] prev_d;
    bit prev_stall, fin;
    int ii, oi, sc, tot, done_n, hs_cyc, first_v, first_in;
    for (int i = 0; i < CA*RA; i++)
      in_q[i] = rnd ? DW'($urandom) : DW'(i);
    sc = SA;
`ifdef UPSAMPLE_BYPASS_EN
    if (byp) sc = 1;
`endif
    for (int r = 0; r < RA; r++)
      for (int v = 0; v < sc; v++)
        for (int c = 0; c < CA; c++)
          for (int h = 0; h < sc; h++)
            exp_q.push_back(in_q[r*CA + c]);
    tot = exp_q.size();
    ii = 0; oi = 0; done_n = 0; fin = 0; prev_stall = 0;
    hs_cyc = -1; first_v = -1; first_in = -1; prev_d = '0;
    @(negedge sclk); a_start = 1'b1; a_byp = byp;
    @(negedge sclk); a_start = 1'b0; a_byp = 1'b0;
    for (int cyc = 0; cyc < 1000 && !fin; cyc++) begin
      if (rst_at >= 0 && oi == rst_at) begin
        s_rst = 1'b1; a_svld = 1'b0; a_mrdy = 1'b1;
        @(negedge sclk); s_rst = 1'b0; #1;
        chk({tag, "_rst"},
            {a_mval, a_mlast, a_busy, a_done, a_srdy}, 5'b0);
        chk({tag, "_rst_data"}, a_mdata, 0);
        repeat (40) begin
          @(negedge sclk); #1;
          if (a_done) done_n++;
        end
        chk({tag, "_rst_nodone"}, done_n, 0);
        return;
      end
      a_start = (cyc == glitch_at);
      a_mrdy  = ($urandom_range(99) < rdy);
      a_svld  = (ii < CA*RA) && ($urandom_range(99) < vld);
      a_sdata = (ii < CA*RA) ? in_q[ii] : DW'($urandom);
      #1;
      if (prev_stall)
        chk({tag, "_hold"}, {a_mval, a_mdata}, {1'b1, prev_d});
      if (a_mval && first_v < 0) first_v = cyc;
      if (a_done) begin
        done_n++;
        fin = 1;
        chk({tag, "_done_t"}, cyc, hs_cyc + 1);
      end
      if (a_mval && a_mrdy) begin
        if (oi < tot) chk({tag, "_data"}, a_mdata, exp_q[oi]);
        else          chk({tag, "_extra"}, oi, tot - 1);
        chk({tag, "_last"}, a_mlast, oi == tot - 1);
        if (oi == tot - 1) hs_cyc = cyc;
        oi++;
      end
      if (a_svld && a_srdy) begin
        if (first_in < 0) first_in = cyc;
        ii++;
      end
      prev_stall = a_mval && !a_mrdy;
      prev_d = a_mdata;
      @(negedge sclk);
    end
    a_start = 1'b0; a_svld = 1'b0;
    chk({tag, "_beats"}, oi, tot);
    chk({tag, "_done_n"}, done_n, 1);
    chk({tag, "_lat"}, first_v, first_in + 1);
    if (rdy == 100 && vld == 100)
      chk({tag, "_nogap"}, hs_cyc - first_v, tot - 1);
    #1;
    chk({tag, "_idle"}, {a_done, a_busy}, 2'b00);
  endtask

  task automatic run_b();
    logic [DW-1:0] in_b [2];
    logic [DW-1:0] exp_q [$];
    int ii, oi, done_n;
    bit fin;
    ii = 0; oi = 0; done_n = 0; fin = 0;
    in_b[0] = DW'($urandom);
    in_b[1] = DW'($urandom);
    for (int v = 0; v < 3; v++)
      for (int c = 0; c < 2; c++)
        for (int h = 0; h < 3; h++)
          exp_q.push_back(in_b[c]);
    @(negedge sclk); b_start = 1'b1;
    @(negedge sclk); b_start = 1'b0; b_mrdy = 1'b1;
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      b_svld  = (ii < 2);
      b_sdata = in_b[ii[0]];
      #1;
      if (b_done) begin done_n++; fin = 1; end
      if (b_mval && b_mrdy) begin
        if (oi < 18) chk("b_data", b_mdata, exp_q[oi]);
        chk("b_last", b_mlast, oi == 17);
        oi++;
      end
      if (b_svld && b_srdy) ii++;
      @(negedge sclk);
    end
    b_svld = 1'b0;
    chk("b_beats", oi, 18);
    chk("b_done_n", done_n, 1);
  endtask

  initial begin
    s_rst = 1'b1;
    a_start = 1'b0; a_byp = 1'b0; a_svld = 1'b0;
    a_mrdy = 1'b0; a_sdata = '0;
    b_start = 1'b0; b_byp = 1'b0; b_svld = 1'b0;
    b_mrdy = 1'b0; b_sdata = '0;
    repeat (3) @(negedge sclk);
    #1;
    chk("reset_ctl", {a_mval, a_mlast, a_busy, a_done, a_srdy}, 5'b0);
    chk("reset_data", a_mdata, 0);
    chk("reset_b", {b_mval, b_busy, b_done, b_srdy}, 4'b0);
    s_rst = 1'b0;

    run_a(1'b0, 100, 100, 1'b0, -1, -1, "seq");
    run_a(1'b0, 50, 50, 1'b0, -1, -1, "bp_seq");
    run_a(1'b0, 50, 70, 1'b1, -1, -1, "bp_rnd");
    run_a(1'b0, 100, 100, 1'b1, -1, 5, "glitch");
    run_a(1'b0, 100, 100, 1'b0, 10, -1, "abort");
    run_a(1'b0, 100, 100, 1'b0, -1, -1, "post");
    run_a(1'b1, 100, 100, 1'b0, -1, -1, "byp");
    run_a(1'b1, 60, 60, 1'b1, -1, -1, "byp_rnd");
    run_a(1'b0, 100, 100, 1'b1, -1, -1, "after_byp");
    run_b();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/upsample_nx.md
UPSAMPLE_NX -- requirements
Module: upsample_nx

Interface
REQ-001 SHALL have parameter DATA_W, default 64: stream beat width in bits.
REQ-002 SHALL have parameter COL_NUM, default 26: input beats per row, range 2..512.
REQ-003 SHALL have parameter ROW_NUM, default 416: input rows per frame, range 1..4096.
REQ-004 SHALL have parameter SCALE, default 2: nearest-neighbour factor applied to both axes, range 1..4.
REQ-005 SHALL have ports (one clock; reset is synchronous and active-high):
- sclk  in  1  sole clock, all logic on the rising edge
- s_rst  in  1  synchronous active-high reset
- start  in  1  one-cycle frame start pulse
- cfg_bypass  in  1  bypass request
- s_tdata  in  DATA_W  input beat
- s_tvalid  in  1  input valid
- s_tready  out  1  input ready
- m_tdata  out  DATA_W  output beat
- m_tvalid  out  1  output valid
- m_tready  in  1  output ready
- m_tlast  out  1  last beat of frame
- busy  out  1  frame in progress
- done  out  1  one-cycle frame-complete pulse

Function
REQ-006 SHALL run FSM IDLE -> FILL -> REPEAT -> (FILL | DONE) -> IDLE.
REQ-007 SHALL leave IDLE only on start=1; start SHALL be ignored in every other state.
REQ-008 In FILL, SHALL accept input beats and emit each one SCALE times consecutively; SHALL write each accepted beat to the line buffer at its column index.
REQ-009 After the COL_NUM-th input beat of a row has been emitted SCALE times, SHALL go to REPEAT; with SCALE=1, SHALL skip REPEAT.
REQ-010 In REPEAT, SHALL replay the stored row from the line buffer SCALE-1 times, each beat SCALE times, with s_tready=0.
REQ-011 At the end of REPEAT, SHALL go to FILL if rows remain, else to DONE.
REQ-012 SHALL hold s_tready=1 only in FILL, on the first horizontal copy, while the output register is empty or m_tready=1.
REQ-013 SHALL register the output: m_tdata and m_tvalid update when m_tvalid=0 or m_tready=1, and are otherwise held stable (AXI-Stream rule).
REQ-014 Latency from input handshake to m_tvalid of its first copy SHALL be 1 cycle.
REQ-015 SHALL sustain 1 beat/cycle with m_tready=1 in both FILL and REPEAT, including across row and state boundaries; the line buffer read is issued one cycle ahead.
REQ-016 Each frame SHALL emit exactly COL_NUM*SCALE*ROW_NUM*SCALE beats.
REQ-017 m_tlast SHALL be 1 only on the final beat of the frame.
REQ-018 done SHALL pulse for one cycle the cycle after the m_tlast handshake; the FSM then returns to IDLE.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 Column, copy, repeat and row counters SHALL wrap at their terminal counts only on a handshake; stalls SHALL never advance any counter.

Reset
REQ-021 On s_rst=1, SHALL set state=IDLE, clear all counters, and drive s_tready=0, m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, done=0.
REQ-022 Reset mid-frame SHALL abandon the frame with no done pulse; line buffer contents are don't-care.

Configuration
REQ-023 With macro UPSAMPLE_BYPASS_EN defined, cfg_bypass sampled at start=1 SHALL select a 1:1 pass-through frame of COL_NUM*ROW_NUM beats, with the same m_tlast and done rules.
REQ-024 Without UPSAMPLE_BYPASS_EN, cfg_bypass SHALL be ignored and no bypass logic SHALL be synthesised.

Structure
REQ-025 State encoding and the counter-width function clog2 SHALL live in shared package upsample_pkg.
REQ-026 The line buffer SHALL be sub-module up_line_buf: simple dual-port, COL_NUM x DATA_W, 1-cycle read latency, inferred RAM, no reset on storage.

Verification
REQ-027 COL_NUM=4, ROW_NUM=2, SCALE=2, inputs 0..7, m_tready=1 -> outputs 0,0,1,1,2,2,3,3 (x2), then 4,4,..,7,7 (x2); 32 beats, m_tlast on beat 32, done on cycle 33, no output bubbles.
REQ-028 Same as REQ-027 with random 50% m_tready and random s_tvalid gaps -> identical sequence; m_tdata stable while m_tvalid=1 and m_tready=0.
REQ-029 SCALE=3, COL_NUM=2, ROW_NUM=1, inputs A,B -> A,A,A,B,B,B repeated 3 times; 18 beats.
REQ-030 UPSAMPLE_BYPASS_EN defined, cfg_bypass=1 at start, inputs 0..7 -> outputs 0..7, m_tlast on 7; without the macro, the same stimulus -> 32-beat upsampled frame.
REQ-031 s_rst=1 asserted at output beat 10 of REQ-027, then a new start -> all outputs at reset values, no done pulse; the second frame is fully correct.
REQ-032 start pulsed while busy=1 -> ignored; beat count and done timing unchanged.
